// File: rtl/regfile_ctrl_if.sv
// Debug/loader access bundle for regfile_ctrl. Signal suffixes are named from
// the controller's point of view: the controller (slave) receives *_i and drives *_o.
interface regfile_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          dbg_req_i;
    logic          dbg_we_i;
    logic [AW-1:0] dbg_addr_i;
    logic [DW-1:0] dbg_wdata_i;
    logic          dbg_ack_o;
    logic [DW-1:0] dbg_rdata_o;

    modport master (
        output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        input  dbg_ack_o, dbg_rdata_o
    );

    modport slave (
        input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
        output dbg_ack_o, dbg_rdata_o
    );
endinterface

// File: rtl/regfile_ctrl.sv
// Register-file access controller: post-reset hardware clear, core/debug
// arbitration of the write port and read port 1, and x0 write suppression.
module regfile_ctrl #(
    parameter int AW             = 5,
    parameter int DW             = 32,
    parameter int NREG           = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [AW-1:0] core_rs1_i,
    input  logic [AW-1:0] core_rs2_i,
    input  logic [AW-1:0] core_rd_i,
    input  logic          core_we_i,
    input  logic [DW-1:0] core_wdata_i,
    output logic [DW-1:0] core_dators1_o,
    output logic [DW-1:0] core_dators2_o,
    output logic          core_stall_o,
    output logic          init_done_o,
    regfile_ctrl_if.slave dbg,
    output logic [AW-1:0] rf_rs1_o,
    output logic [AW-1:0] rf_rs2_o,
    output logic [AW-1:0] rf_rd_o,
    output logic          rf_we_o,
    output logic [DW-1:0] rf_wdata_o,
    input  logic [DW-1:0] rf_dators1_i,
    input  logic [DW-1:0] rf_dators2_i
);
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DBG   = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    localparam logic [AW-1:0] ZERO_A   = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_A    = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] LAST_A   = AW'(NREG - 1);
    localparam logic [DW-1:0] ZERO_D   = {DW{1'b0}};
    localparam state_t        ST_START = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic          DONE_RST = (CLEAR_ON_RESET == 0);

    state_t        r_state;
    logic [AW-1:0] r_clr_cnt;
    logic [DW-1:0] r_dbg_rdata;
    logic          r_init_done;

    logic [AW-1:0] w_rs1;
    logic [AW-1:0] w_rd;
    logic          w_we;
    logic [DW-1:0] w_wdata;
    logic          w_stall;
    logic          w_ack;

    // Sequencer: state, clear counter, debug read capture and init flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_START;
            r_clr_cnt   <= ZERO_A;
            r_dbg_rdata <= ZERO_D;
            r_init_done <= DONE_RST;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_cnt == LAST_A) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                        r_clr_cnt   <= ZERO_A;
                    end else begin
                        r_clr_cnt   <= r_clr_cnt + ONE_A;
                    end
                end
                ST_RUN: begin
                    if (dbg.dbg_req_i) begin
                        r_state <= ST_DBG;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DBG: begin
                    // Reads sample the async port before any write lands.
                    if (!dbg.dbg_we_i) begin
                        r_dbg_rdata <= rf_dators1_i;
                    end
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state     <= ST_START;
                    r_clr_cnt   <= ZERO_A;
                    r_init_done <= DONE_RST;
                end
            endcase
        end
    end

    // Port routing decoded from the current state; stalled by default.
    always_comb begin
        w_rs1   = core_rs1_i;
        w_rd    = core_rd_i;
        w_wdata = core_wdata_i;
        w_we    = 1'b0;
        w_stall = 1'b1;
        w_ack   = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_rd    = r_clr_cnt;
                w_wdata = ZERO_D;
            end
            ST_RUN: begin
                w_we    = core_we_i && (core_rd_i != ZERO_A);
                w_stall = 1'b0;
            end
            ST_DBG: begin
                w_rs1   = dbg.dbg_addr_i;
                w_rd    = dbg.dbg_addr_i;
                w_wdata = dbg.dbg_wdata_i;
                w_we    = dbg.dbg_we_i && (dbg.dbg_addr_i != ZERO_A);
            end
            ST_ACK: begin
                w_ack   = 1'b1;
            end
            default: begin
                w_we    = 1'b0;
            end
        endcase
    end

    assign rf_rs1_o        = w_rs1;
    assign rf_rs2_o        = core_rs2_i;
    assign rf_rd_o         = w_rd;
    assign rf_we_o         = w_we;
    assign rf_wdata_o      = w_wdata;
    assign core_dators1_o  = rf_dators1_i;
    assign core_dators2_o  = rf_dators2_i;
    assign core_stall_o    = w_stall;
    assign init_done_o     = r_init_done;
    assign dbg.dbg_ack_o   = w_ack;
    assign dbg.dbg_rdata_o = r_dbg_rdata;
endmodule

// File: tb/tb_regfile_ctrl.sv
// Randomized bench for regfile_ctrl with a behavioural register file and an
// architectural reference model of the expected register contents.
module tb_regfile_ctrl;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [AW-1:0] core_rs1_i, core_rs2_i, core_rd_i;
    logic          core_we_i;
    logic [DW-1:0] core_wdata_i;
    logic [DW-1:0] core_dators1_o, core_dators2_o;
    logic          core_stall_o, init_done_o;
    logic [AW-1:0] rf_rs1_o, rf_rs2_o, rf_rd_o;
    logic          rf_we_o;
    logic [DW-1:0] rf_wdata_o, rf_dators1_i, rf_dators2_i;

    regfile_ctrl_if #(.AW(AW), .DW(DW)) dbg_if ();

    regfile_ctrl #(.AW(AW), .DW(DW), .NREG(NREG), .CLEAR_ON_RESET(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .core_rs1_i(core_rs1_i), .core_rs2_i(core_rs2_i), .core_rd_i(core_rd_i),
        .core_we_i(core_we_i), .core_wdata_i(core_wdata_i),
        .core_dators1_o(core_dators1_o), .core_dators2_o(core_dators2_o),
        .core_stall_o(core_stall_o), .init_done_o(init_done_o),
        .dbg(dbg_if),
        .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o), .rf_rd_o(rf_rd_o),
        .rf_we_o(rf_we_o), .rf_wdata_o(rf_wdata_o),
        .rf_dators1_i(rf_dators1_i), .rf_dators2_i(rf_dators2_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural 32x32 register file: one write port, two async reads.
    logic          preload = 1'b0;
    logic [DW-1:0] mem [NREG];
    always @(posedge clk_i) begin
        if (preload) begin
            for (int k = 0; k < NREG; k++) mem[k] <= 32'hFFFF_FFFF;
        end else if (rf_we_o) begin
            mem[rf_rd_o] <= rf_wdata_o;
        end
    end
    assign rf_dators1_i = mem[rf_rs1_o];
    assign rf_dators2_i = mem[rf_rs2_o];

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] ref_mem [NREG];
    logic [DW-1:0] exp_rdata   = 32'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full clear from cnt=0; abort_at>=0 pulls reset when the counter shows that value.
    task automatic run_clear(input int abort_at);
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk_i);
            check_eq("clr_stall", 32'(core_stall_o), 32'd1);
            check_eq("clr_we",    32'(rf_we_o),      32'd1);
            check_eq("clr_rd",    32'(rf_rd_o),      32'(i));
            check_eq("clr_wdata", rf_wdata_o,        32'd0);
            check_eq("clr_ack",   32'(dbg_if.dbg_ack_o), 32'd0);
            check_eq("clr_done",  32'(init_done_o),  32'd0);
            check_eq("clr_rdata", dbg_if.dbg_rdata_o, exp_rdata);
            if (i == abort_at) begin
                rst_ni = 1'b0;
                @(posedge clk_i); #1;
                rst_ni = 1'b1;
                exp_rdata = 32'd0;
                return;
            end
            @(posedge clk_i); #1;
        end
        for (int k = 0; k < NREG; k++) ref_mem[k] = 32'd0;
    endtask

    task automatic core_cycle(input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] wd,
                              input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        core_we_i = we; core_rd_i = rd; core_wdata_i = wd;
        core_rs1_i = rs1; core_rs2_i = rs2;
        dbg_if.dbg_req_i = 1'b0;
        @(negedge clk_i);
        check_eq("run_stall", 32'(core_stall_o), 32'd0);
        check_eq("run_done",  32'(init_done_o),  32'd1);
        check_eq("run_we",    32'(rf_we_o),      32'(we && (rd != 5'd0)));
        check_eq("run_ack",   32'(dbg_if.dbg_ack_o), 32'd0);
        check_eq("rd1",       core_dators1_o,    ref_mem[rs1]);
        check_eq("rd2",       core_dators2_o,    ref_mem[rs2]);
        @(posedge clk_i); #1;
        if (we && rd != 5'd0) ref_mem[rd] = wd;
        core_we_i = 1'b0;
    endtask

    // One debug transaction issued in a RUN cycle, optionally with a core write alongside.
    task automatic dbg_xact(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input logic cwe, input logic [AW-1:0] crd, input logic [DW-1:0] cwd,
                            input logic hold);
        dbg_if.dbg_req_i = 1'b1; dbg_if.dbg_we_i = we;
        dbg_if.dbg_addr_i = addr; dbg_if.dbg_wdata_i = wd;
        core_we_i = cwe; core_rd_i = crd; core_wdata_i = cwd;
        @(negedge clk_i);
        check_eq("req_stall", 32'(core_stall_o), 32'd0);
        check_eq("req_we",    32'(rf_we_o),      32'(cwe && (crd != 5'd0)));
        check_eq("req_ack",   32'(dbg_if.dbg_ack_o), 32'd0);
        @(posedge clk_i); #1;
        if (cwe && crd != 5'd0) ref_mem[crd] = cwd;
        core_we_i = 1'b1; core_rd_i = AW'($urandom); core_wdata_i = $urandom;
        @(negedge clk_i);
        check_eq("dbg_stall", 32'(core_stall_o), 32'd1);
        check_eq("dbg_ack",   32'(dbg_if.dbg_ack_o), 32'd0);
        check_eq("dbg_we",    32'(rf_we_o),      32'(we && (addr != 5'd0)));
        check_eq("dbg_rd",    32'(rf_rd_o),      32'(addr));
        check_eq("dbg_rs1",   32'(rf_rs1_o),     32'(addr));
        @(posedge clk_i); #1;
        if (!we) exp_rdata = ref_mem[addr];
        if (we && addr != 5'd0) ref_mem[addr] = wd;
        if (!hold) dbg_if.dbg_req_i = 1'b0;
        @(negedge clk_i);
        check_eq("ack_pulse", 32'(dbg_if.dbg_ack_o), 32'd1);
        check_eq("ack_stall", 32'(core_stall_o), 32'd1);
        check_eq("ack_we",    32'(rf_we_o),      32'd0);
        check_eq("ack_rdata", dbg_if.dbg_rdata_o, exp_rdata);
        @(posedge clk_i); #1;
        core_we_i = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        rst_ni = 1'b0; core_we_i = 1'b0; core_rd_i = '0; core_wdata_i = '0;
        core_rs1_i = '0; core_rs2_i = '0;
        dbg_if.dbg_req_i = 1'b0; dbg_if.dbg_we_i = 1'b0;
        dbg_if.dbg_addr_i = '0; dbg_if.dbg_wdata_i = '0;
        preload = 1'b1;
        @(posedge clk_i); #1;
        preload = 1'b0;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check_eq("rst_done",  32'(init_done_o), 32'd0);
        check_eq("rst_ack",   32'(dbg_if.dbg_ack_o), 32'd0);
        check_eq("rst_rdata", dbg_if.dbg_rdata_o, 32'd0);
        check_eq("rst_stall", 32'(core_stall_o), 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        run_clear(-1);
        for (int i = 0; i < NREG; i++) core_cycle(1'b0, 5'd0, 32'd0, AW'(i), AW'(NREG - 1 - i));

        // Directed: core writes, x0 suppression, debug write/read with concurrent core write.
        core_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        core_cycle(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd5, 5'd0);
        core_cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd5);
        dbg_xact(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0);
        dbg_xact(1'b0, 5'd7, 32'd0, 1'b1, 5'd9, 32'hCAFE_F00D, 1'b0);
        core_cycle(1'b0, 5'd0, 32'd0, 5'd9, 5'd7);
        dbg_xact(1'b1, 5'd0, 32'hFFFF_0000, 1'b0, 5'd0, 32'd0, 1'b0);
        dbg_xact(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        dbg_xact(1'b1, 5'd12, 32'hA5A5_5A5A, 1'b0, 5'd0, 32'd0, 1'b1);
        dbg_xact(1'b0, 5'd12, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);

        // Randomized mix of core cycles, single and back-to-back debug transactions.
        for (int n = 0; n < 200; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom);
            d = $urandom;
            if (sel < 5) begin
                core_cycle(1'($urandom), a, d, AW'($urandom), AW'($urandom));
            end else if (sel < 9) begin
                dbg_xact(1'($urandom), a, d, 1'($urandom), AW'($urandom), $urandom, 1'b0);
            end else begin
                dbg_xact(1'b1, a, d, 1'b0, 5'd0, 32'd0, 1'b1);
                dbg_xact(1'b0, AW'($urandom), 32'd0, 1'($urandom), AW'($urandom), $urandom, 1'b0);
            end
        end
        for (int i = 0; i < NREG; i++) core_cycle(1'b0, 5'd0, 32'd0, AW'(i), AW'(NREG - 1 - i));

        // Reset mid-clear at clr_cnt=17, then a full clear.
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        exp_rdata = 32'd0;
        run_clear(17);
        run_clear(-1);
        for (int i = 0; i < NREG; i++) core_cycle(1'b0, 5'd0, 32'd0, AW'(i), AW'(NREG - 1 - i));

        // Reset while a debug read is in DBG: no ack, clear restarts.
        dbg_xact(1'b1, 5'd3, 32'h0BAD_CAFE, 1'b0, 5'd0, 32'd0, 1'b0);
        dbg_xact(1'b0, 5'd3, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        dbg_if.dbg_req_i = 1'b1; dbg_if.dbg_we_i = 1'b0; dbg_if.dbg_addr_i = 5'd3;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(negedge clk_i);
        check_eq("abort_stall", 32'(core_stall_o), 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        dbg_if.dbg_req_i = 1'b0;
        exp_rdata = 32'd0;
        run_clear(-1);

        // Request held through a clear is serviced once RUN is reached.
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        dbg_if.dbg_req_i = 1'b1; dbg_if.dbg_we_i = 1'b1;
        dbg_if.dbg_addr_i = 5'd21; dbg_if.dbg_wdata_i = 32'h5555_AAAA;
        run_clear(-1);
        dbg_xact(1'b1, 5'd21, 32'h5555_AAAA, 1'b0, 5'd0, 32'd0, 1'b0);
        dbg_xact(1'b0, 5'd21, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < NREG; i++) core_cycle(1'b0, 5'd0, 32'd0, AW'(i), AW'(NREG - 1 - i));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
